// File: rtl/mac_share_sched_pkg.sv
// Shared types for the multiplier-sharing scheduler.
//   state_e : scheduler control states
//   tag_t   : one tag-pipeline entry {valid, originating requester id}
package mac_share_sched_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at i_ptr and the first requesting
// index (wrapping) wins.
//   i_req      : request vector
//   i_ptr      : highest-priority index for this cycle
//   o_grant    : one-hot grant (zero when nothing requests)
//   o_grant_id : index of the granted requester
//   o_any      : at least one request present
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotate so that bit 0 of w_rot is requester i_ptr.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = NUM_REQ'(w_req2 >> i_ptr);

    // Priority pick on the rotated vector, then map back to a real index.
    always_comb begin
        o_any      = 1'b0;
        o_grant_id = '0;
        o_grant    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any      = 1'b1;
                o_grant_id = ID_W'((32'(i_ptr) + k) % NUM_REQ);
            end
        end
        if (o_any) begin
            o_grant[o_grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/mac_share_sched.sv
// Shares one pipelined multiplier between NUM_REQ requesters. Operands are
// issued combinationally to the granted requester, a {valid,id} tag follows
// each operation through PIPE_LAT stages, and the whole pipe freezes while a
// response is back-pressured.
//   clock0/aclr0_n           : clock, async active-low reset
//   req_valid/ready/data/sign: per-requester operand handshake
//   flush/flush_done         : stop issuing, pulse once drained
//   mult_*                   : shared multiplier operands, stage enable, result
//   rsp_valid/ready/id/result: response handshake
//   busy                     : anything in flight or not idle
module mac_share_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WIDTH_A      = 16,
    parameter int unsigned WIDTH_B      = 16,
    parameter int unsigned WIDTH_RESULT = 32,
    parameter int unsigned PIPE_LAT     = 3
) (
    input  logic                         clock0,
    input  logic                         aclr0_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [WIDTH_A*NUM_REQ-1:0]   req_dataa,
    input  logic [WIDTH_B*NUM_REQ-1:0]   req_datab,
    input  logic [2*NUM_REQ-1:0]         req_sign,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [WIDTH_A-1:0]           mult_dataa,
    output logic [WIDTH_B-1:0]           mult_datab,
    output logic                         mult_signa,
    output logic                         mult_signb,
    output logic                         mult_ena,
    input  logic [WIDTH_RESULT-1:0]      mult_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH_RESULT-1:0]      rsp_result,
    output logic                         busy
);
    import mac_share_sched_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [ID_W-1:0]          r_rr_ptr;
    tag_t [PIPE_LAT-1:0]      r_tag;
    tag_t [PIPE_LAT-1:0]      w_tag_nxt;

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_grant_id;
    logic                     w_any;
    logic                     w_stall;
    logic                     w_issue;
    logic                     w_tag_any;
    logic                     w_tag_upper;
    logic                     w_tag_keep;
    logic [1:0]               w_sign_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req      (req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // Response side comes straight off the last tag stage.
    assign rsp_valid  = r_tag[PIPE_LAT-1].valid;
    assign rsp_id     = ID_W'(r_tag[PIPE_LAT-1].id);
    assign rsp_result = mult_result;

    assign w_stall  = rsp_valid & ~rsp_ready;
    assign mult_ena = ~w_stall;

    // w_tag_upper: any valid that would remain after one shift (all but last).
    always_comb begin
        w_tag_any   = 1'b0;
        w_tag_upper = 1'b0;
        for (int unsigned i = 0; i < PIPE_LAT; i++) begin
            w_tag_any = w_tag_any | r_tag[i].valid;
            if (i + 1 < PIPE_LAT) begin
                w_tag_upper = w_tag_upper | r_tag[i].valid;
            end
        end
    end

    // Pipe non-empty after this edge, assuming nothing is issued.
    assign w_tag_keep = w_stall ? w_tag_any : w_tag_upper;

    // Control FSM next-state / issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        flush_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else if (|req_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_issue = w_any & ~w_stall;
                    if (!w_issue && !w_tag_keep) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_tag_any) begin
                    flush_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready = w_issue ? w_grant : '0;
    assign busy      = (r_state != ST_IDLE) | w_tag_any;

    // Operand mux: granted slice on issue, zero otherwise.
    always_comb begin
        mult_dataa = '0;
        mult_datab = '0;
        w_sign_sel = 2'b00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_issue && w_grant[i]) begin
                mult_dataa = req_dataa[i*WIDTH_A +: WIDTH_A];
                mult_datab = req_datab[i*WIDTH_B +: WIDTH_B];
                w_sign_sel = req_sign[2*i +: 2];
            end
        end
        mult_signa = w_sign_sel[0];
        mult_signb = w_sign_sel[1];
    end

    // Tag shift, gated by the same enable as the multiplier stages.
    always_comb begin
        w_tag_nxt = r_tag;
        if (mult_ena) begin
            w_tag_nxt[0].valid = w_issue;
            w_tag_nxt[0].id    = TAG_ID_W'(w_grant_id);
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                w_tag_nxt[i] = r_tag[i-1];
            end
        end
    end

    // State, pointer and tag registers.
    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_tag    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
            if (w_issue) begin
                r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                               : w_grant_id + ID_W'(1);
            end
        end
    end

endmodule
